// File: rtl/usb_link_sched.sv
// Transaction sequencer between the protocol FSM and the dpdm line block.
// Define LINK_RETRY_EN to retry failed attempts up to MAX_RETRY times.
module usb_link_sched #(
    parameter int TIMEOUT_CYC = 255,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       txn_valid,
    input  logic       txn_kind,
    output logic       txn_ready,
    output logic [1:0] w_pkt_type,
    output logic       re,
    input  logic       rx_done,
    input  logic [1:0] rx_status,
    output logic       txn_done,
    output logic [1:0] txn_result,
    output logic [3:0] retry_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TX_TOK  = 3'd1;
    localparam logic [2:0] S_TX_DATA = 3'd2;
    localparam logic [2:0] S_TX_HS   = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_RX_WAIT = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    // Hold lengths are packet size + 4 (stream, 2x SE0, J); counters count from 0.
    localparam logic [6:0] TOK_LAST  = 7'd35;
    localparam logic [6:0] DATA_LAST = 7'd99;
    localparam logic [6:0] HS_LAST   = 7'd19;
    localparam logic [9:0] TMO_LAST  = 10'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ST_ACK  = 2'b00;
    localparam logic [1:0] ST_NAK  = 2'b01;
    localparam logic [1:0] ST_DATA = 2'b10;

    localparam logic [1:0] RES_OK  = 2'b00;
    localparam logic [1:0] RES_TMO = 2'b01;
    localparam logic [1:0] RES_NAK = 2'b10;
    localparam logic [1:0] RES_ERR = 2'b11;

`ifdef LINK_RETRY_EN
    localparam logic RETRY_EN = 1'b1;
`else
    localparam logic RETRY_EN = 1'b0;
`endif
    localparam logic [4:0] RETRY_CFG = {RETRY_EN, 4'(MAX_RETRY)};

    logic [2:0] state_q, state_d;
    logic [2:0] gap_next_q, gap_next_d;
    logic       kind_q, kind_d;
    logic [6:0] hold_q, hold_d;
    logic [9:0] tmo_q, tmo_d;
    logic [3:0] retry_q, retry_d;
    logic [1:0] res_q, res_d;
    logic       ok_s, fail_s, retry_ok_s;
    logic [1:0] fail_code_s;
    logic [1:0] pkt_s;

    logic       txn_ready_q;
    logic [1:0] w_pkt_type_q;
    logic       re_q;
    logic       txn_done_q;
    logic [1:0] txn_result_q;

    assign retry_ok_s = RETRY_CFG[4] && (retry_q < RETRY_CFG[3:0]);

    // Next-state, attempt outcome and retry bookkeeping.
    always_comb begin
        state_d     = state_q;
        gap_next_d  = gap_next_q;
        kind_d      = kind_q;
        retry_d     = retry_q;
        res_d       = res_q;
        ok_s        = 1'b0;
        fail_s      = 1'b0;
        fail_code_s = RES_ERR;
        case (state_q)
            S_IDLE: begin
                if (txn_valid) begin
                    state_d = S_TX_TOK;
                    kind_d  = txn_kind;
                    retry_d = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TX_TOK: begin
                if (hold_q == TOK_LAST) begin
                    state_d    = S_GAP;
                    gap_next_d = kind_q ? S_RX_WAIT : S_TX_DATA;
                end else begin
                    state_d = S_TX_TOK;
                end
            end
            S_TX_DATA: begin
                if (hold_q == DATA_LAST) begin
                    state_d    = S_GAP;
                    gap_next_d = S_RX_WAIT;
                end else begin
                    state_d = S_TX_DATA;
                end
            end
            S_TX_HS: begin
                if (hold_q == HS_LAST) begin
                    state_d    = S_GAP;
                    gap_next_d = S_DONE;
                end else begin
                    state_d = S_TX_HS;
                end
            end
            S_GAP: begin
                state_d = gap_next_q;
            end
            S_RX_WAIT: begin
                // A response on the final timeout cycle takes priority over the timeout.
                if (rx_done) begin
                    case (rx_status)
                        ST_ACK: begin
                            if (!kind_q) begin
                                ok_s    = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                fail_s = 1'b1;
                            end
                        end
                        ST_DATA: begin
                            if (kind_q) begin
                                ok_s       = 1'b1;
                                state_d    = S_GAP;
                                gap_next_d = S_TX_HS;
                            end else begin
                                fail_s = 1'b1;
                            end
                        end
                        ST_NAK: begin
                            fail_s      = 1'b1;
                            fail_code_s = RES_NAK;
                        end
                        default: begin
                            fail_s = 1'b1;
                        end
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    fail_s      = 1'b1;
                    fail_code_s = RES_TMO;
                end else begin
                    state_d = S_RX_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fail_s && retry_ok_s) begin
            res_d      = fail_code_s;
            retry_d    = retry_q + 4'd1;
            state_d    = S_GAP;
            gap_next_d = S_TX_TOK;
        end else if (fail_s) begin
            res_d   = fail_code_s;
            state_d = S_DONE;
        end else if (ok_s) begin
            res_d = RES_OK;
        end else begin
            res_d = res_q;
        end
    end

    // Hold and timeout counters restart whenever their state is entered.
    always_comb begin
        hold_d = (state_d != state_q) ? 7'd0 : hold_q + 7'd1;
        if ((state_q == S_RX_WAIT) && (state_d == S_RX_WAIT)) begin
            tmo_d = tmo_q + 10'd1;
        end else begin
            tmo_d = 10'd0;
        end
    end

    // Packet-type code presented to the writer for the upcoming state.
    always_comb begin
        case (state_d)
            S_TX_TOK:  pkt_s = 2'b01;
            S_TX_DATA: pkt_s = 2'b10;
            S_TX_HS:   pkt_s = 2'b11;
            default:   pkt_s = 2'b00;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gap_next_q   <= S_IDLE;
            kind_q       <= 1'b0;
            hold_q       <= 7'd0;
            tmo_q        <= 10'd0;
            retry_q      <= 4'd0;
            res_q        <= RES_OK;
            txn_ready_q  <= 1'b1;
            w_pkt_type_q <= 2'b00;
            re_q         <= 1'b0;
            txn_done_q   <= 1'b0;
            txn_result_q <= RES_OK;
        end else begin
            state_q      <= state_d;
            gap_next_q   <= gap_next_d;
            kind_q       <= kind_d;
            hold_q       <= hold_d;
            tmo_q        <= tmo_d;
            retry_q      <= retry_d;
            res_q        <= res_d;
            txn_ready_q  <= (state_d == S_IDLE);
            w_pkt_type_q <= pkt_s;
            re_q         <= (state_d == S_RX_WAIT);
            txn_done_q   <= (state_d == S_DONE);
            txn_result_q <= (state_d == S_DONE) ? res_d : txn_result_q;
        end
    end

    assign txn_ready  = txn_ready_q;
    assign w_pkt_type = w_pkt_type_q;
    assign re         = re_q;
    assign txn_done   = txn_done_q;
    assign txn_result = txn_result_q;
    assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_usb_link_sched.sv
// Randomized bench for usb_link_sched: expected per-cycle line activity is
// generated from the transaction rules and compared every cycle.
module tb_usb_link_sched;

    localparam int TMO  = 8;
    localparam int MAXR = 3;
`ifdef LINK_RETRY_EN
    localparam int RLIM = MAXR;
`else
    localparam int RLIM = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       txn_valid;
    logic       txn_kind;
    logic       txn_ready;
    logic [1:0] w_pkt_type;
    logic       re;
    logic       rx_done;
    logic [1:0] rx_status;
    logic       txn_done;
    logic [1:0] txn_result;
    logic [3:0] retry_cnt;

    usb_link_sched #(.TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)) dut (
        .clk        (clk),
        .rst        (rst),
        .txn_valid  (txn_valid),
        .txn_kind   (txn_kind),
        .txn_ready  (txn_ready),
        .w_pkt_type (w_pkt_type),
        .re         (re),
        .rx_done    (rx_done),
        .rx_status  (rx_status),
        .txn_done   (txn_done),
        .txn_result (txn_result),
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] w;
        logic       re;
        logic       done;
        logic [1:0] res;
        logic [3:0] rty;
        logic       rxd;
        logic [1:0] rxs;
    } step_t;

    step_t      tl[$];
    int         rt[4];
    logic [1:0] rs[4];
    logic [1:0] last_res;
    logic [3:0] mdl_retry;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         txn_no  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int n, input logic [1:0] w, input logic r);
        step_t e;
        for (int i = 0; i < n; i++) begin
            e.w = w; e.re = r; e.done = 1'b0; e.res = last_res;
            e.rty = mdl_retry; e.rxd = 1'b0; e.rxs = 2'b00;
            tl.push_back(e);
        end
    endtask

    // Whole transaction laid out cycle by cycle from the response plan.
    task automatic build_txn(input logic kind);
        int         a;
        bit         fin;
        bit         ok;
        logic [1:0] code;
        step_t      e;
        tl.delete();
        mdl_retry = 4'd0;
        a = 0;
        fin = 1'b0;
        code = 2'b00;
        while (!fin) begin
            push(36, 2'b01, 1'b0);
            push(1, 2'b00, 1'b0);
            if (!kind) begin
                push(100, 2'b10, 1'b0);
                push(1, 2'b00, 1'b0);
            end
            ok = 1'b0;
            code = 2'b01;
            if (rt[a] == 0) begin
                push(TMO, 2'b00, 1'b1);
            end else begin
                push(rt[a], 2'b00, 1'b1);
                e = tl.pop_back();
                e.rxd = 1'b1;
                e.rxs = rs[a];
                tl.push_back(e);
                if (!kind && rs[a] == 2'b00) ok = 1'b1;
                else if (kind && rs[a] == 2'b10) ok = 1'b1;
                else if (rs[a] == 2'b01) code = 2'b10;
                else code = 2'b11;
            end
            if (ok) begin
                if (kind) begin
                    push(1, 2'b00, 1'b0);
                    push(20, 2'b11, 1'b0);
                    push(1, 2'b00, 1'b0);
                end
                code = 2'b00;
                fin = 1'b1;
            end else if (a < RLIM) begin
                a++;
                mdl_retry = 4'(a);
                push(1, 2'b00, 1'b0);
            end else begin
                fin = 1'b1;
            end
        end
        last_res = code;
        push(1, 2'b00, 1'b0);
        e = tl.pop_back();
        e.done = 1'b1;
        tl.push_back(e);
    endtask

    task automatic drive_cycle(input logic v, input logic k, input logic rxd, input logic [1:0] rxs,
                               input logic [10:0] exp, input string tag);
        txn_valid = v; txn_kind = k; rx_done = rxd; rx_status = rxs;
        @(negedge clk);
        check_val(tag, {21'd0, txn_ready, w_pkt_type, re, txn_done, txn_result, retry_cnt}, {21'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic set_plan(input int r, input logic [1:0] s);
        for (int i = 0; i < 4; i++) begin
            rt[i] = r;
            rs[i] = s;
        end
    endtask

    task automatic run_txn(input logic kind, input int idle, input int abort_at);
        step_t e;
        logic  rxd;
        txn_no++;
        for (int i = 0; i < idle; i++) begin
            drive_cycle(1'b0, 1'($urandom), 1'($urandom), 2'($urandom),
                        {1'b1, 2'b00, 1'b0, 1'b0, last_res, mdl_retry}, $sformatf("t%0d_idle", txn_no));
        end
        drive_cycle(1'b1, kind, 1'($urandom), 2'($urandom),
                    {1'b1, 2'b00, 1'b0, 1'b0, last_res, mdl_retry}, $sformatf("t%0d_accept", txn_no));
        build_txn(kind);
        for (int i = 0; i < tl.size(); i++) begin
            e = tl[i];
            rxd = e.re ? e.rxd : 1'($urandom);
            if (i == abort_at) begin
                txn_valid = 1'b0; rx_done = rxd; rx_status = 2'($urandom);
                @(negedge clk);
                #2 rst = 1'b1;
                #1 check_val($sformatf("t%0d_async_rst", txn_no), {29'd0, w_pkt_type, re}, 32'd0);
                @(posedge clk);
                #1 rst = 1'b0;
                last_res = 2'b00;
                mdl_retry = 4'd0;
                drive_cycle(1'b0, 1'b0, 1'b0, 2'b00, {1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 4'd0},
                            $sformatf("t%0d_post_rst", txn_no));
                return;
            end
            drive_cycle(1'($urandom), 1'($urandom), rxd, e.rxd ? e.rxs : 2'($urandom),
                        {1'b0, e.w, e.re, e.done, e.res, e.rty}, $sformatf("t%0d_cyc%0d", txn_no, i));
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; txn_valid = 1'b0; txn_kind = 1'b0; rx_done = 1'b0; rx_status = 2'b00;
        last_res = 2'b00;
        mdl_retry = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_state", {21'd0, txn_ready, w_pkt_type, re, txn_done, txn_result, retry_cnt},
                  {21'd0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 4'd0});
        @(posedge clk);
        #1 rst = 1'b0;

        set_plan(5, 2'b00);   run_txn(1'b0, 2, -1);   // OUT, ACK 5 cycles into RX_WAIT
        set_plan(3, 2'b10);   run_txn(1'b1, 0, -1);   // IN, DATA good, back-to-back
        set_plan(4, 2'b01);   run_txn(1'b0, 1, -1);   // OUT, NAK every attempt
        set_plan(0, 2'b00);   run_txn(1'b1, 1, -1);   // IN, no response
        set_plan(TMO, 2'b00); run_txn(1'b0, 0, -1);   // ACK on the timeout cycle
        set_plan(5, 2'b00);   run_txn(1'b0, 1, 87);   // reset during TX_DATA
        run_txn(1'b0, 1, -1);

        for (int n = 0; n < 20; n++) begin
            for (int a = 0; a < 4; a++) begin
                rt[a] = $urandom_range(0, TMO);
                rs[a] = 2'($urandom);
            end
            run_txn(1'($urandom), $urandom_range(0, 3), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_link_sched.md
# usb_link_sched

Transaction sequencer for the DP/DM line interface. It accepts one OUT or IN transaction from the protocol FSM and drives the writer's packet-type code for each outgoing packet for the exact bit-time it needs. It then turns the bus around to read and waits for the device response, bounded by a timeout. It retries failed attempts and reports a single result per transaction, sitting between the protocol FSM and the dpdm block.

## Interface
- TIMEOUT_CYC, 255: cycles allowed in RX_WAIT before declaring timeout (1..1023)
- MAX_RETRY, 3: retries after the first attempt (0..15)

- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- txn_valid  in  1  transaction request
- txn_kind  in  1  0 = OUT (token, data, expect handshake); 1 = IN (token, expect data, send ACK)
- txn_ready  out  1  high in IDLE only
- w_pkt_type  out  2  to writer's packet-type input: 00 idle/J, 01 token, 10 data, 11 handshake
- re  out  1  read enable to dpdm
- rx_done  in  1  one-cycle end-of-packet pulse from the reader
- rx_status  in  2  decoded response, sampled only with rx_done: 00 ACK, 01 NAK, 10 DATA good, 11 error
- txn_done  out  1  one-cycle completion pulse
- txn_result  out  2  valid with txn_done: 00 success, 01 timeout, 10 NAK, 11 error; holds its value until the next txn_done
- retry_cnt  out  4  retries used by the current or last transaction

## Operation
- States: IDLE, TX_TOK, TX_DATA, TX_HS, GAP, RX_WAIT, DONE.
- Packet hold lengths are packet size + 4 cycles: stream 0..S inclusive, plus 2 SE0, plus 1 J.
  - Token: w_pkt_type = 01 for 36 cycles.
  - Data: w_pkt_type = 10 for 100 cycles.
  - Handshake: w_pkt_type = 11 for 20 cycles.
- A 7-bit hold counter times each packet and clears on state entry.
- Every TX state is followed by exactly one GAP cycle with w_pkt_type = 00, so the writer counter clears. GAP then advances to the next step.
- OUT sequence: TX_TOK, GAP, TX_DATA, GAP, RX_WAIT.
- IN sequence: TX_TOK, GAP, RX_WAIT.
- RX_WAIT: re = 1 and a 10-bit timeout counter counts from 0. Response handling:
  - OUT + ACK: success.
  - IN + DATA good: GAP, then TX_HS (ACK), then GAP, then success.
  - NAK, error, DATA on OUT, or ACK on IN: attempt failed with result NAK, error, error and error respectively.
  - Timeout counter reaches TIMEOUT_CYC with no rx_done: attempt failed with result timeout.
- A failed attempt goes to a retry if retry_cnt < MAX_RETRY: retry_cnt increments, then GAP, then TX_TOK. Otherwise the FSM goes to DONE with that failure code.
- DONE: txn_done = 1 for one cycle, then IDLE.
- retry_cnt clears when a new transaction is accepted.
- rx_done outside RX_WAIT is ignored. txn_valid outside IDLE is ignored.

## Timing
- Reset values: txn_ready 1 after release, w_pkt_type 00, re 0, txn_done 0, txn_result 00, retry_cnt 0, state IDLE.
- Reset mid-transaction forces these values asynchronously. The writer falls back to J immediately.
- Acceptance on the edge where txn_valid && txn_ready. w_pkt_type = 01 from the next cycle.
- re is high only in RX_WAIT. It drops the cycle after rx_done is sampled or after the timeout.
- If rx_done arrives in the same cycle the counter reaches TIMEOUT_CYC, rx_done wins.
- Minimum OUT transaction, acceptance to txn_done with ACK returned k cycles into RX_WAIT: 36 + 1 + 100 + 1 + k + 1 cycles.
- txn_ready rises the cycle after txn_done. A back-to-back request is accepted on that cycle.

## Configuration
- LINK_RETRY_EN defined: retry behaviour as above.
- LINK_RETRY_EN undefined:
  - The first failed attempt goes directly to DONE.
  - retry_cnt is tied to 0.
  - MAX_RETRY is ignored.

## Test plan
- OUT, ACK returned 5 cycles into RX_WAIT:
  - 01 for 36 cycles, 00 for 1, 10 for 100, 00 for 1, then re = 1.
  - txn_done with result 00 and retry_cnt 0.
- IN, DATA good:
  - TX_HS drives 11 for exactly 20 cycles between single 00 GAP cycles.
  - Result 00.
- OUT, NAK on every attempt, MAX_RETRY = 3, LINK_RETRY_EN defined: 4 token packets, result 10, retry_cnt 3.
- IN, no response, TIMEOUT_CYC = 8:
  - re high for 8 cycles per attempt.
  - With LINK_RETRY_EN undefined: a single attempt, result 01.
- rx_done asserted on the exact timeout cycle with ACK (OUT): result 00, not 01.
- rst pulsed during TX_DATA: w_pkt_type 00 and re 0 immediately; the next txn_valid starts a clean token of 36 cycles.
